bin2bcd_param: RTL and testbench

- Parametrised sequential binary-to-BCD converter using double-dabble: one shift-with-correction per clock.
- Configurable input width and digit count, optional two's-complement signed input, overflow detection, and a leading-zero blank mask.
- Sits between value producers (sensor/counter registers) and the Nokia 5110 text path. Its BCD digits index the glyph RAM; the blank mask suppresses leading-zero glyphs.

---
 rtl/bin2bcd_param.sv | 89 ++++++++
 tb/tb_bin2bcd_param.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_param.sv
// bin2bcd_param: sequential double-dabble binary-to-BCD converter; ports: clk, nrst (sync active-low), in, start -> bcd, neg, ovf, blank, busy, done
module bin2bcd_param #(
  parameter int IN_W      = 8,
  parameter int DIGITS    = 3,
  parameter int SIGNED_EN = 0,
  parameter int BLANK_LZ  = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [IN_W-1:0]       in,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;
  state_t state, state_nx;
  logic [BW-1:0] dig, dig_c;
  logic [IN_W-1:0] mag, mag_in;
  logic [IN_W:0] neg_full;
  logic [CW-1:0] cnt;
  logic [DIGITS-1:0] blank_w;
  logic sgn, ovf_w, neg_in, last, lz;
  // negation at IN_W+1 bits so the most negative input maps to its true magnitude
  assign neg_in   = SIGNED_EN != 0 && in[IN_W-1];
  assign neg_full = -{in[IN_W-1], in};
  assign mag_in   = neg_in ? neg_full[IN_W-1:0] : in;
  assign last     = cnt == CW'(IN_W - 1);
  assign busy     = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (start ? CONV : IDLE) :
               state == CONV ? (last ? FINISH : CONV) : IDLE;
  end
  always_comb begin
    dig_c = dig;
    for (int d = 0; d < DIGITS; d++)
      dig_c[4*d +: 4] = dig[4*d +: 4] >= 4'd5 ? dig[4*d +: 4] + 4'd3 : dig[4*d +: 4];
  end
  // digit i is blank when it and every digit above it are zero
  always_comb begin
    blank_w = '0;
    lz = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz = lz && dig[4*i +: 4] == 4'd0;
      blank_w[i] = BLANK_LZ != 0 && lz;
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      dig   <= '0;
      mag   <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      ovf_w <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      blank <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state == FINISH;
      if (state == IDLE && start) begin
        mag   <= mag_in;
        sgn   <= neg_in;
        dig   <= '0;
        cnt   <= '0;
        ovf_w <= 1'b0;
      end
      if (state == CONV) begin
        {dig, mag} <= {dig_c, mag} << 1;
        ovf_w      <= ovf_w | dig_c[BW-1];
        cnt        <= cnt + 1'b1;
      end
      if (state == FINISH) begin
        bcd   <= dig;
        neg   <= sgn;
        ovf   <= ovf_w;
        blank <= blank_w;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_param.sv
// tb_bin2bcd_param: randomized and directed self-checking bench for bin2bcd_param across five parameter sets
module tb_bin2bcd_param;
  logic clk = 1'b0, nrst = 1'b0, start = 1'b0;
  logic [15:0] v_in = '0;
  int cyc = 0, acc = 0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] b0, b1, b2; logic [7:0] b3; logic [19:0] b4;
  logic [2:0] k0, k1, k2; logic [1:0] k3; logic [4:0] k4;
  logic g0, g1, g2, g3, g4, o0, o1, o2, o3, o4, y0, y1, y2, y3, y4, d0, d1, d2, d3, d4;
  logic [11:0] cb0, cb1, cb2; logic [7:0] cb3; logic [19:0] cb4;
  logic [2:0] ck0, ck1, ck2; logic [1:0] ck3; logic [4:0] ck4;
  logic cg0, cg1, cg2, cg3, cg4, co0, co1, co2, co3, co4;
  int n0 = 0, n1 = 0, n2 = 0, n3 = 0, n4 = 0, t0 = 0, t4 = 0;

  bin2bcd_param #(.IN_W(8), .DIGITS(3), .SIGNED_EN(0), .BLANK_LZ(1)) u0 (.clk(clk), .nrst(nrst), .in(v_in[7:0]), .start(start),
    .bcd(b0), .neg(g0), .ovf(o0), .blank(k0), .busy(y0), .done(d0));
  bin2bcd_param #(.IN_W(8), .DIGITS(3), .SIGNED_EN(0), .BLANK_LZ(0)) u1 (.clk(clk), .nrst(nrst), .in(v_in[7:0]), .start(start),
    .bcd(b1), .neg(g1), .ovf(o1), .blank(k1), .busy(y1), .done(d1));
  bin2bcd_param #(.IN_W(8), .DIGITS(3), .SIGNED_EN(1), .BLANK_LZ(1)) u2 (.clk(clk), .nrst(nrst), .in(v_in[7:0]), .start(start),
    .bcd(b2), .neg(g2), .ovf(o2), .blank(k2), .busy(y2), .done(d2));
  bin2bcd_param #(.IN_W(8), .DIGITS(2), .SIGNED_EN(0), .BLANK_LZ(1)) u3 (.clk(clk), .nrst(nrst), .in(v_in[7:0]), .start(start),
    .bcd(b3), .neg(g3), .ovf(o3), .blank(k3), .busy(y3), .done(d3));
  bin2bcd_param #(.IN_W(16), .DIGITS(5), .SIGNED_EN(0), .BLANK_LZ(1)) u4 (.clk(clk), .nrst(nrst), .in(v_in), .start(start),
    .bcd(b4), .neg(g4), .ovf(o4), .blank(k4), .busy(y4), .done(d4));

  always @(negedge clk) if (d0) begin cb0 <= b0; cg0 <= g0; co0 <= o0; ck0 <= k0; n0 <= n0 + 1; t0 <= cyc; end
  always @(negedge clk) if (d1) begin cb1 <= b1; cg1 <= g1; co1 <= o1; ck1 <= k1; n1 <= n1 + 1; end
  always @(negedge clk) if (d2) begin cb2 <= b2; cg2 <= g2; co2 <= o2; ck2 <= k2; n2 <= n2 + 1; end
  always @(negedge clk) if (d3) begin cb3 <= b3; cg3 <= g3; co3 <= o3; ck3 <= k3; n3 <= n3 + 1; end
  always @(negedge clk) if (d4) begin cb4 <= b4; cg4 <= g4; co4 <= o4; ck4 <= k4; n4 <= n4 + 1; t4 <= cyc; end

  // reference: magnitude by arithmetic, digits by repeated division, blanks by comparing against powers of ten
  task automatic model(input longint v, input int w, input int d, input bit s, input bit bl,
                       output longint eb, output bit en, output bit eo, output int ek);
    longint x, mag, lim, r, p;
    x = v & ((64'd1 << w) - 1);
    en = s && x[w-1];
    mag = en ? (64'd1 << w) - x : x;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    eo = mag >= lim;
    r = mag % lim;
    ek = 0;
    p = 10;
    for (int i = 1; i < d; i++) begin
      if (bl && r < p) ek = ek | (1 << i);
      p = p * 10;
    end
    eb = 0;
    for (int i = 0; i < d; i++) begin
      eb = eb | ((r % 10) << (4 * i));
      r = r / 10;
    end
  endtask

  task automatic convert(input logic [15:0] v);
    int s0, s1, s2, s3, s4;
    s0 = n0; s1 = n1; s2 = n2; s3 = n3; s4 = n4;
    @(negedge clk);
    v_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    for (int i = 0; i < 40 && (n0 == s0 || n1 == s1 || n2 == s2 || n3 == s3 || n4 == s4); i++) begin
      @(negedge clk);
      #1;
    end
    vectors++;
    if (n0 == s0 || n1 == s1 || n2 == s2 || n3 == s3 || n4 == s4) begin
      miscompares++;
      $display("FAIL done_timeout: got dones %0d/%0d/%0d/%0d/%0d required one more each", n0 - s0, n1 - s1, n2 - s2, n3 - s3, n4 - s4);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({b0, g0, o0, k0, y0, d0, b4, y4, d4} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got bcd=%h neg=%b ovf=%b blank=%b busy=%b done=%b required all 0", b0, g0, o0, k0, y0, d0);
    end
    nrst = 1'b1;
  endtask

  task automatic test_unsigned;
    logic [15:0] tv [2] = '{16'd176, 16'd255};
    longint eb; bit en, eo; int ek;
    for (int i = 0; i < 2; i++) begin
      convert(tv[i]);
      model(tv[i], 8, 3, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({cg0, co0, ck0, cb0} !== {en, eo, ek[2:0], eb[11:0]}) begin
        miscompares++;
        $display("FAIL unsigned_%0d: got neg=%b ovf=%b blank=%b bcd=%h required %b %b %b %h", tv[i], cg0, co0, ck0, cb0, en, eo, ek[2:0], eb[11:0]);
      end
      vectors++;
      if (t0 - acc !== 9) begin
        miscompares++;
        $display("FAIL latency_8: got %0d required 9", t0 - acc);
      end
    end
    vectors++;
    if (cb0 !== 12'h255) begin
      miscompares++;
      $display("FAIL literal_255: got %h required 255", cb0);
    end
  endtask

  task automatic test_blank;
    logic [15:0] tv [2] = '{16'd0, 16'd7};
    longint eb; bit en, eo; int ek;
    for (int i = 0; i < 2; i++) begin
      convert(tv[i]);
      model(tv[i], 8, 3, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({cb0, ck0} !== {eb[11:0], ek[2:0]} || ck0 !== 3'b110) begin
        miscompares++;
        $display("FAIL blank_lz_%0d: got bcd=%h blank=%b required %h %b", tv[i], cb0, ck0, eb[11:0], ek[2:0]);
      end
      model(tv[i], 8, 3, 0, 0, eb, en, eo, ek);
      vectors++;
      if ({cb1, ck1} !== {eb[11:0], ek[2:0]}) begin
        miscompares++;
        $display("FAIL blank_off_%0d: got bcd=%h blank=%b required %h %b", tv[i], cb1, ck1, eb[11:0], ek[2:0]);
      end
    end
  endtask

  task automatic test_signed;
    logic [15:0] tv [4] = '{16'h80, 16'hFF, 16'h7F, 16'h00};
    longint eb; bit en, eo; int ek;
    for (int i = 0; i < 4; i++) begin
      convert(tv[i]);
      model(tv[i], 8, 3, 1, 1, eb, en, eo, ek);
      vectors++;
      if ({cg2, co2, ck2, cb2} !== {en, eo, ek[2:0], eb[11:0]}) begin
        miscompares++;
        $display("FAIL signed_%h: got neg=%b ovf=%b blank=%b bcd=%h required %b %b %b %h", tv[i], cg2, co2, ck2, cb2, en, eo, ek[2:0], eb[11:0]);
      end
    end
  endtask

  task automatic test_digits;
    logic [15:0] tv [3] = '{16'd176, 16'd99, 16'd100};
    longint eb; bit en, eo; int ek;
    for (int i = 0; i < 3; i++) begin
      convert(tv[i]);
      model(tv[i], 8, 2, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({co3, ck3, cb3} !== {eo, ek[1:0], eb[7:0]}) begin
        miscompares++;
        $display("FAIL digits2_%0d: got ovf=%b blank=%b bcd=%h required %b %b %h", tv[i], co3, ck3, cb3, eo, ek[1:0], eb[7:0]);
      end
    end
  endtask

  task automatic test_wide;
    logic [15:0] tv [2] = '{16'd65535, 16'd1000};
    longint eb; bit en, eo; int ek;
    for (int i = 0; i < 2; i++) begin
      convert(tv[i]);
      model(tv[i], 16, 5, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({co4, ck4, cb4} !== {eo, ek[4:0], eb[19:0]}) begin
        miscompares++;
        $display("FAIL wide_%0d: got ovf=%b blank=%b bcd=%h required %b %b %h", tv[i], co4, ck4, cb4, eo, ek[4:0], eb[19:0]);
      end
      vectors++;
      if (t4 - acc !== 17) begin
        miscompares++;
        $display("FAIL latency_16: got %0d required 17", t4 - acc);
      end
    end
  endtask

  task automatic test_random;
    longint eb; bit en, eo; int ek;
    logic [15:0] v;
    for (int i = 0; i < 25; i++) begin
      v = 16'($urandom);
      convert(v);
      model(v, 8, 3, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({cg0, co0, ck0, cb0} !== {en, eo, ek[2:0], eb[11:0]}) begin
        miscompares++;
        $display("FAIL rand_u0 in=%h: got %b %b %b %h required %b %b %b %h", v, cg0, co0, ck0, cb0, en, eo, ek[2:0], eb[11:0]);
      end
      model(v, 8, 3, 0, 0, eb, en, eo, ek);
      vectors++;
      if ({cg1, co1, ck1, cb1} !== {en, eo, ek[2:0], eb[11:0]}) begin
        miscompares++;
        $display("FAIL rand_u1 in=%h: got %b %b %b %h required %b %b %b %h", v, cg1, co1, ck1, cb1, en, eo, ek[2:0], eb[11:0]);
      end
      model(v, 8, 3, 1, 1, eb, en, eo, ek);
      vectors++;
      if ({cg2, co2, ck2, cb2} !== {en, eo, ek[2:0], eb[11:0]}) begin
        miscompares++;
        $display("FAIL rand_u2 in=%h: got %b %b %b %h required %b %b %b %h", v, cg2, co2, ck2, cb2, en, eo, ek[2:0], eb[11:0]);
      end
      model(v, 8, 2, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({cg3, co3, ck3, cb3} !== {en, eo, ek[1:0], eb[7:0]}) begin
        miscompares++;
        $display("FAIL rand_u3 in=%h: got %b %b %b %h required %b %b %b %h", v, cg3, co3, ck3, cb3, en, eo, ek[1:0], eb[7:0]);
      end
      model(v, 16, 5, 0, 1, eb, en, eo, ek);
      vectors++;
      if ({cg4, co4, ck4, cb4} !== {en, eo, ek[4:0], eb[19:0]}) begin
        miscompares++;
        $display("FAIL rand_u4 in=%h: got %b %b %b %h required %b %b %b %h", v, cg4, co4, ck4, cb4, en, eo, ek[4:0], eb[19:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int tms [3];
    int cnt = 0, last = n0;
    @(negedge clk);
    v_in = 16'd123;
    start = 1'b1;
    for (int i = 0; i < 60 && cnt < 3; i++) begin
      @(negedge clk);
      #1;
      if (n0 != last) begin
        tms[cnt] = t0;
        cnt++;
        last = n0;
      end
    end
    start = 1'b0;
    vectors++;
    if (cnt !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d required 3", cnt);
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (tms[i] - tms[i-1] !== 10) begin
          miscompares++;
          $display("FAIL b2b_spacing: got %0d required 10", tms[i] - tms[i-1]);
        end
      end
    end
    vectors++;
    if (cb0 !== 12'h123) begin
      miscompares++;
      $display("FAIL b2b_value: got %h required 123", cb0);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_busy_ignored;
    int s0 = n0, bad = 0;
    logic [11:0] prev = cb0;
    longint eb; bit en, eo; int ek;
    @(negedge clk);
    v_in = 16'd50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    v_in = 16'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (n0 == s0 && b0 !== prev) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL hold_stable: got %0d changed cycles required 0", bad);
    end
    vectors++;
    if (n0 - s0 !== 1) begin
      miscompares++;
      $display("FAIL busy_ignore_dones: got %0d required 1", n0 - s0);
    end
    model(16'd50, 8, 3, 0, 1, eb, en, eo, ek);
    vectors++;
    if (cb0 !== eb[11:0]) begin
      miscompares++;
      $display("FAIL busy_ignore_value: got %h required %h", cb0, eb[11:0]);
    end
  endtask

  task automatic test_reset_mid;
    int s0;
    longint eb; bit en, eo; int ek;
    @(negedge clk);
    v_in = 16'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    s0 = n0;
    vectors++;
    if ({b0, g0, o0, k0, y0, d0} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got bcd=%h neg=%b ovf=%b blank=%b busy=%b done=%b required all 0", b0, g0, o0, k0, y0, d0);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (n0 !== s0) begin
      miscompares++;
      $display("FAIL mid_reset_done: got %0d dones required 0", n0 - s0);
    end
    convert(16'd42);
    model(16'd42, 8, 3, 0, 1, eb, en, eo, ek);
    vectors++;
    if (cb0 !== 12'h042 || cb0 !== eb[11:0]) begin
      miscompares++;
      $display("FAIL after_reset_42: got %h required 042", cb0);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_blank;
    test_signed;
    test_digits;
    test_wide;
    test_random;
    test_back_to_back;
    test_busy_ignored;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
